// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS32 controller: states, opcodes, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXECUTE = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JUMP    = 4'd12,
    TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Raw per-state controls. irwrite/pcwrite_rdy are qualified by mem_ready
  // and branch by zero in the top; everything else drives ports directly.
  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       pcwrite;
    logic       pcwrite_rdy;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  // States whose single cycle always completes the instruction.
  function automatic logic retires_always(state_t s);
    return (s == MEMWB) || (s == ALUWB) || (s == BRANCH) ||
           (s == ADDIWB) || (s == JUMP);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore decoder: maps the controller state to raw datapath selects and enables.
// Latency: purely combinational, zero cycles.
// Backpressure: none; memory-ready and zero qualification happen in the top.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Decode the state register into the per-state control word
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memread     = 1'b1;
        ctrl.alusrcb     = ALUSRCB_FOUR;
        ctrl.aluop       = ALUOP_ADD;
        ctrl.pcsrc       = PCSRC_ALU;
        ctrl.irwrite     = 1'b1;
        ctrl.pcwrite_rdy = 1'b1;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while the opcode decodes
        ctrl.alusrcb = ALUSRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.memread = 1'b1;
      end
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_B;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS32 main controller: sequences fetch/decode/execute/mem/wb and counts retires.
// Latency: 3-5 cycles per instruction with memory always ready; outputs are Moore except irwrite/pcen.
// Backpressure: stalls in FETCH, MEMRD and MEMWR until mem_ready; mem_ready elsewhere is ignored.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             memtoreg,
  output logic             regdst,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             irwrite,
  output logic             regwrite,
  output logic             memwrite,
  output logic             memread,
  output logic             pcen,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q;
  state_t           state_d;
  ctrl_t            ctrl;
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // State register; reset drops straight to IDLE so every enable clears at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection from current state, opcode and memory handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // Port drive: Moore selects, with the FETCH and BRANCH enables qualified by inputs
  always_comb begin
    iord     = ctrl.iord;
    alusrca  = ctrl.alusrca;
    alusrcb  = ctrl.alusrcb;
    memtoreg = ctrl.memtoreg;
    regdst   = ctrl.regdst;
    pcsrc    = ctrl.pcsrc;
    aluop    = ctrl.aluop;
    regwrite = ctrl.regwrite;
    memwrite = ctrl.memwrite;
    memread  = ctrl.memread;
    illegal  = ctrl.illegal;
    irwrite  = ctrl.irwrite & mem_ready;
    pcen     = ctrl.pcwrite | (ctrl.pcwrite_rdy & mem_ready) | (ctrl.branch & zero);
  end

  // An instruction retires on the edge that leaves its final state
  always_comb begin
    retire = retires_always(state_q) | ((state_q == MEMWR) & mem_ready);
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: scoreboard of per-cycle expected outputs.
// Latency: n/a.
// Backpressure: exercised through mem_ready stall patterns.
module tb_mc_control_fsm;

  typedef enum {S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP} tst_t;

  typedef struct {
    logic [15:0] vec;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  typedef struct {
    logic mr;
    logic z;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        iord, alusrca, memtoreg, regdst, irwrite, regwrite, memwrite, memread, pcen, illegal;
  logic [1:0]  alusrcb, pcsrc, aluop;
  logic [31:0] instr_count;

  logic        w_iord, w_alusrca, w_memtoreg, w_regdst, w_irwrite, w_regwrite, w_memwrite, w_memread, w_pcen, w_illegal;
  logic [1:0]  w_alusrcb, w_pcsrc, w_aluop;
  logic [2:0]  w_count;

  logic [15:0] obs_vec, w_vec;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;
  exp_t        exp_q[$];
  stim_t       stim_q[$];

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .zero (zero), .mem_ready (mem_ready),
    .iord (iord), .alusrca (alusrca), .alusrcb (alusrcb), .memtoreg (memtoreg),
    .regdst (regdst), .pcsrc (pcsrc), .aluop (aluop), .irwrite (irwrite),
    .regwrite (regwrite), .memwrite (memwrite), .memread (memread), .pcen (pcen),
    .illegal (illegal), .instr_count (instr_count)
  );

  // Narrow-counter instance shadows the main one so counter wrap is reachable
  mc_control_fsm #(.CNT_W(3)) dut_w (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .zero (zero), .mem_ready (mem_ready),
    .iord (w_iord), .alusrca (w_alusrca), .alusrcb (w_alusrcb), .memtoreg (w_memtoreg),
    .regdst (w_regdst), .pcsrc (w_pcsrc), .aluop (w_aluop), .irwrite (w_irwrite),
    .regwrite (w_regwrite), .memwrite (w_memwrite), .memread (w_memread), .pcen (w_pcen),
    .illegal (w_illegal), .instr_count (w_count)
  );

  assign obs_vec = {iord, alusrca, alusrcb, memtoreg, regdst, pcsrc, aluop,
                    irwrite, regwrite, memwrite, memread, pcen, illegal};
  assign w_vec   = {w_iord, w_alusrca, w_alusrcb, w_memtoreg, w_regdst, w_pcsrc, w_aluop,
                    w_irwrite, w_regwrite, w_memwrite, w_memread, w_pcen, w_illegal};

  // Expected output word per state, written from the controller's output table
  function automatic logic [15:0] exp_vec(tst_t st, logic mr, logic z);
    logic       e_iord, e_asa, e_mtr, e_rdst, e_irw, e_rw, e_mw, e_mrd, e_pcen, e_ill;
    logic [1:0] e_asb, e_pcs, e_aop;
    e_iord = 1'b0; e_asa = 1'b0; e_mtr = 1'b0; e_rdst = 1'b0; e_irw = 1'b0;
    e_rw = 1'b0; e_mw = 1'b0; e_mrd = 1'b0; e_pcen = 1'b0; e_ill = 1'b0;
    e_asb = 2'b00; e_pcs = 2'b00; e_aop = 2'b00;
    case (st)
      S_FETCH:   begin e_mrd = 1'b1; e_asb = 2'b01; e_irw = mr; e_pcen = mr; end
      S_DECODE:  begin e_asb = 2'b11; end
      S_MEMADR:  begin e_asa = 1'b1; e_asb = 2'b10; end
      S_MEMRD:   begin e_iord = 1'b1; e_mrd = 1'b1; end
      S_MEMWB:   begin e_mtr = 1'b1; e_rw = 1'b1; end
      S_MEMWR:   begin e_iord = 1'b1; e_mw = 1'b1; end
      S_EXECUTE: begin e_asa = 1'b1; e_aop = 2'b10; end
      S_ALUWB:   begin e_rdst = 1'b1; e_rw = 1'b1; end
      S_BRANCH:  begin e_asa = 1'b1; e_aop = 2'b01; e_pcs = 2'b01; e_pcen = z; end
      S_ADDIEX:  begin e_asa = 1'b1; e_asb = 2'b10; end
      S_ADDIWB:  begin e_rw = 1'b1; end
      S_JUMP:    begin e_pcs = 2'b10; e_pcen = 1'b1; end
      S_TRAP:    begin e_ill = 1'b1; end
      default: ;
    endcase
    return {e_iord, e_asa, e_asb, e_mtr, e_rdst, e_pcs, e_aop,
            e_irw, e_rw, e_mw, e_mrd, e_pcen, e_ill};
  endfunction

  // Queue one cycle of stimulus together with the outputs it must produce
  task automatic add(input tst_t st, input logic mr, input logic z);
    exp_t  e;
    stim_t s;
    e.vec = exp_vec(st, mr, z);
    e.cnt = model_cnt;
    e.tag = st.name();
    s.mr  = mr;
    s.z   = z;
    exp_q.push_back(e);
    stim_q.push_back(s);
    if (st == S_MEMWB || st == S_ALUWB || st == S_BRANCH || st == S_ADDIWB ||
        st == S_JUMP || (st == S_MEMWR && mr))
      model_cnt = model_cnt + 32'd1;
  endtask

  // Drive queued stimulus one cycle at a time and compare mid-cycle
  task automatic run();
    while (stim_q.size() > 0) begin
      stim_t s;
      exp_t  e;
      s = stim_q.pop_front();
      @(negedge clk);
      mem_ready = s.mr;
      zero      = s.z;
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e.vec) begin
        errors++;
        $display("FAIL %s outputs got %h want %h", e.tag, obs_vec, e.vec);
      end
      checks++;
      if (instr_count !== e.cnt) begin
        errors++;
        $display("FAIL %s instr_count got %0d want %0d", e.tag, instr_count, e.cnt);
      end
      checks++;
      if (w_vec !== e.vec) begin
        errors++;
        $display("FAIL %s narrow outputs got %h want %h", e.tag, w_vec, e.vec);
      end
      checks++;
      if (w_count !== e.cnt[2:0]) begin
        errors++;
        $display("FAIL %s narrow count got %0d want %0d", e.tag, w_count, e.cnt[2:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (obs_vec !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0000", obs_vec);
    end
    checks++;
    if (instr_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", instr_count);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs_vec !== 16'h0000) begin
      errors++;
      $display("FAIL idle_outputs got %h want 0000", obs_vec);
    end
  endtask

  task automatic test_lw();
    opcode = 6'b100011;
    add(S_FETCH, 1'b1, 1'b0);
    add(S_DECODE, 1'b1, 1'b1);
    add(S_MEMADR, 1'b1, 1'b0);
    add(S_MEMRD, 1'b1, 1'b0);
    add(S_MEMWB, 1'b1, 1'b1);
    run();
  endtask

  task automatic test_sw_stall();
    opcode = 6'b101011;
    add(S_FETCH, 1'b1, 1'b0);
    add(S_DECODE, 1'b0, 1'b0);
    add(S_MEMADR, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(S_MEMWR, 1'b0, 1'b1);
    add(S_MEMWR, 1'b1, 1'b0);
    run();
  endtask

  task automatic test_beq();
    opcode = 6'b000100;
    add(S_FETCH, 1'b1, 1'b0);
    add(S_DECODE, 1'b1, 1'b1);
    add(S_BRANCH, 1'b0, 1'b1);
    add(S_FETCH, 1'b1, 1'b1);
    add(S_DECODE, 1'b1, 1'b0);
    add(S_BRANCH, 1'b1, 1'b0);
    run();
  endtask

  task automatic test_fetch_stall();
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) add(S_FETCH, 1'b0, 1'(i % 2));
    add(S_FETCH, 1'b1, 1'b0);
    add(S_DECODE, 1'b0, 1'b0);
    add(S_EXECUTE, 1'b1, 1'b1);
    add(S_ALUWB, 1'b0, 1'b1);
    run();
  endtask

  task automatic test_back_to_back();
    opcode = 6'b001000;
    add(S_FETCH, 1'b1, 1'b0);
    add(S_DECODE, 1'b1, 1'b0);
    add(S_ADDIEX, 1'b1, 1'b1);
    add(S_ADDIWB, 1'b1, 1'b1);
    run();
    opcode = 6'b000010;
    add(S_FETCH, 1'b1, 1'b0);
    add(S_DECODE, 1'b1, 1'b0);
    add(S_JUMP, 1'b0, 1'b0);
    run();
  endtask

  task automatic test_wrap();
    opcode = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      add(S_FETCH, 1'b1, 1'b0);
      add(S_DECODE, 1'b1, 1'b0);
      add(S_JUMP, 1'b1, 1'b1);
    end
    run();
  endtask

  task automatic test_trap();
    opcode = 6'b111111;
    add(S_FETCH, 1'b1, 1'b0);
    add(S_DECODE, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      add(S_TRAP, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    run();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_cnt = 32'd0;
    #1;
    checks++;
    if (obs_vec !== 16'h0000) begin
      errors++;
      $display("FAIL trap_reset_outputs got %h want 0000", obs_vec);
    end
    checks++;
    if (instr_count !== 32'd0) begin
      errors++;
      $display("FAIL trap_reset_count got %0d want 0", instr_count);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset_memwr();
    opcode = 6'b101011;
    add(S_FETCH, 1'b1, 1'b0);
    add(S_DECODE, 1'b1, 1'b0);
    add(S_MEMADR, 1'b1, 1'b0);
    add(S_MEMWR, 1'b0, 1'b0);
    add(S_MEMWR, 1'b0, 1'b0);
    run();
    @(posedge clk);
    #2;
    checks++;
    if (memwrite !== 1'b1 || iord !== 1'b1) begin
      errors++;
      $display("FAIL memwr_hold got memwrite=%b iord=%b want 1 1", memwrite, iord);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (memwrite !== 1'b0 || obs_vec !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset got memwrite=%b outputs %h want 0 0000", memwrite, obs_vec);
    end
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs_vec !== 16'h0000 || instr_count !== 32'd0 || w_count !== 3'd0) begin
      errors++;
      $display("FAIL held_reset got outputs %h count %0d narrow %0d want 0000 0 0",
               obs_vec, instr_count, w_count);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_fetch_stall();
    test_back_to_back();
    test_wrap();
    test_trap();
    test_async_reset_memwr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main controller for the multicycle MIPS32 datapath.
- Sequences one shared ALU and one unified memory port across FETCH/DECODE/EXECUTE/MEM/WB steps.
- Drives every datapath mux select (IorD, ALUSrcA, ALUSrcB, MemtoReg, RegDst, PCSrc) and all write enables.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  instr[31:26] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- iord  output  1  memory address mux: 0 = PC, 1 = ALUOut.
- alusrca  output  1  0 = PC, 1 = register A.
- alusrcb  output  2  00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- memtoreg  output  1  0 = ALUOut, 1 = MDR.
- regdst  output  1  0 = rt, 1 = rd.
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- irwrite  output  1  instruction register load.
- regwrite  output  1  register file write.
- memwrite  output  1  memory write request.
- memread  output  1  memory read request.
- pcen  output  1  PC load (pcwrite | branch&zero).
- illegal  output  1  sticky trap flag.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, instr_count=0, illegal=0.
  - All outputs 0; all selects 0.
- IDLE:
  - All outputs 0.
  - Moves to FETCH on the first clock edge after rst_n deasserts.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - While mem_ready=0: stay; irwrite=0, pcen=0.
  - When mem_ready=1: irwrite=1, pcen=1, go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - 100011 lw → MEMADR
  - 101011 sw → MEMADR
  - 000000 R-type → EXECUTE
  - 000100 beq → BRANCH
  - 001000 addi → ADDIEX
  - 000010 j → JUMP
  - anything else → TRAP
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, memread=1. Wait for mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Retire, go to FETCH.
- MEMWR: iord=1, memwrite=1, held for the whole wait. When mem_ready=1: retire, go to FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Go to ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Retire, go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch internal=1 so pcen=zero. Retire, go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Retire, go to FETCH.
- JUMP: pcsrc=10, pcen=1. Retire, go to FETCH.
- TRAP:
  - illegal=1; all enables 0.
  - Stays in TRAP until reset. instr_count frozen.
- "Retire": instr_count increments by 1 on the same edge that leaves the retiring state. It wraps modulo 2^CNT_W with no flag.
- Any state not listed above, if decoded, returns to IDLE.
- Output timing:
  - Selects and aluop are Moore outputs, decoded from the state register only.
  - irwrite and pcen in FETCH are Mealy on mem_ready; pcen in BRANCH is Mealy on zero. No other input→output combinational paths.
- Per-instruction cycle counts with mem_ready tied to 1:
  - lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- rst_n asserted mid-instruction: immediate IDLE, all enables 0 the same instant. No partial writes after assertion.
- mem_ready asserted outside FETCH, MEMRD and MEMWR is ignored.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encoding: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP;
  - opcode constants;
  - ALUSRCB_*, PCSRC_*, ALUOP_* encodings.
- Sub-module mc_ctrl_outdec: purely combinational state→output decoder.
- The top holds the state register, next-state logic, counter, and the Mealy gating.

Test Plan:
- Reset then `lw` (100011), mem_ready=1 → states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 only in MEMWB with memtoreg=1; instr_count=1.
- `sw` with mem_ready low 3 cycles in MEMWR → memwrite=1 held 4 cycles, iord=1, no regwrite, count +1 only on the ready cycle.
- `beq` with zero=1, then again with zero=0 → pcen=1 with pcsrc=01 in BRANCH the first time, pcen=0 the second; both retire, count=2.
- FETCH with mem_ready=0 for 5 cycles → irwrite=0 and pcen=0 throughout; single irwrite pulse when ready rises.
- opcode 111111 → TRAP, illegal=1, all enables 0 for 20 cycles, count unchanged; rst_n low → illegal=0, state IDLE.
- Assert rst_n mid-MEMWR → memwrite drops asynchronously; count preset to 0xFFFFFFFF then one retire → wraps to 0.
